// File: rtl/left_rotate_iter_if.sv
// Start/busy/done handshake bundle for the iterative left rotator.
// The requester drives operand and count; the rotator returns status and result.
interface left_rotate_iter_if #(
    parameter int N = 16,
    parameter int C = 4
) ();
    logic         start;
    logic [N-1:0] In;
    logic [C-1:0] Cnt;
    logic         busy;
    logic         done;
    logic [N-1:0] Out;

    modport master (
        output start, In, Cnt,
        input  busy, done, Out
    );

    modport slave (
        input  start, In, Cnt,
        output busy, done, Out
    );
endinterface

// File: rtl/left_rotate_iter.sv
// Multi-cycle left barrel rotator: one power-of-two stage per clock, largest stage first.
// Fixed latency of C busy cycles followed by a one-cycle done pulse; Out holds between completions.
module left_rotate_iter #(
    parameter int N = 16,
    parameter int C = 4
) (
    input  logic              clk,
    input  logic              rst,
    left_rotate_iter_if.slave rotBus
);
    localparam int IW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT         state;
    stateT         nextState;
    logic [N-1:0]  workReg;
    logic [N-1:0]  outReg;
    logic [C-1:0]  cntReg;
    logic [IW-1:0] stageIdx;

    logic          accept;
    logic          lastStage;
    logic [C:0]    shiftAmt;
    logic [C:0]    backAmt;
    logic [N-1:0]  rotated;
    logic [N-1:0]  stageResult;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        lastStage = 1'b0;
        unique case (state)
            IDLE: begin
                if (rotBus.start) begin
                    accept    = 1'b1;
                    nextState = ROT;
                end
            end
            ROT: begin
                // start is deliberately ignored here; the in-flight operation is never disturbed
                if (stageIdx == '0) begin
                    lastStage = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                if (rotBus.start) begin
                    accept    = 1'b1;
                    nextState = ROT;
                end else begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Current stage rotates by 2^stageIdx, applied only when that count bit is set.
    always_comb begin
        shiftAmt    = (C + 1)'(1) << stageIdx;
        backAmt     = (C + 1)'(N) - shiftAmt;
        rotated     = (workReg << shiftAmt) | (workReg >> backAmt);
        stageResult = cntReg[stageIdx] ? rotated : workReg;
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the working and result registers are ordinary flops, so they are cleared here too.
            state    <= IDLE;
            workReg  <= '0;
            cntReg   <= '0;
            outReg   <= '0;
            stageIdx <= IW'(C - 1);
        end else begin
            state <= nextState;
            if (accept) begin
                workReg  <= rotBus.In;
                cntReg   <= rotBus.Cnt;
                stageIdx <= IW'(C - 1);
            end else if (state == ROT) begin
                workReg <= stageResult;
                if (lastStage) begin
                    outReg <= stageResult;
                end else begin
                    stageIdx <= stageIdx - IW'(1);
                end
            end
        end
    end

    assign rotBus.busy = (state == ROT);
    assign rotBus.done = (state == DONE);
    assign rotBus.Out  = outReg;
endmodule

// File: tb/tb_left_rotate_iter.sv
// Directed and swept checks of left_rotate_iter against a modulo-N rotate model.
// Expected results are queued when a start is driven and popped on the done pulse.
module tb_left_rotate_iter;
    localparam int N = 16;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    left_rotate_iter_if #(.N(N), .C(C)) rotBus ();

    left_rotate_iter #(.N(N), .C(C)) dut (
        .clk    (clk),
        .rst    (rst),
        .rotBus (rotBus.slave)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] expQ[$];
    logic [N-1:0] prevOut;

    function automatic logic [N-1:0] rotModel(input logic [N-1:0] v, input int c);
        logic [2*N-1:0] dbl;
        dbl = {v, v} << c;
        return dbl[2*N-1:N];
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives a one-cycle start; returns at the negedge of the first busy cycle.
    task automatic startOp(input logic [N-1:0] inVal, input logic [C-1:0] cntVal, input bit push);
        @(negedge clk);
        prevOut          = rotBus.Out;
        rotBus.start     = 1'b1;
        rotBus.In        = inVal;
        rotBus.Cnt       = cntVal;
        if (push) expQ.push_back(rotModel(inVal, int'(cntVal)));
        @(negedge clk);
        rotBus.start     = 1'b0;
    endtask

    // Counts busy cycles until done, scrambling In/Cnt meanwhile, then checks the result.
    task automatic finishOp(input string tag, input int alreadyBusy, input bit idleAfter);
        int           busyCount;
        bit           held;
        logic [N-1:0] exp;
        busyCount = alreadyBusy;
        held      = 1'b1;
        for (int i = 0; i < 50 && !rotBus.done; i++) begin
            if (rotBus.busy) busyCount++;
            if (rotBus.Out !== prevOut) held = 1'b0;
            rotBus.In  = N'($urandom);
            rotBus.Cnt = C'($urandom);
            @(negedge clk);
        end
        check({tag, " done"}, 32'(rotBus.done), 32'd1);
        check({tag, " busyCycles"}, 32'(busyCount), 32'(C));
        check({tag, " outHeld"}, 32'(held), 32'd1);
        if (expQ.size() > 0) exp = expQ.pop_front();
        else exp = 'x;
        check({tag, " Out"}, 32'(rotBus.Out), 32'(exp));
        if (idleAfter) begin
            @(negedge clk);
            check({tag, " donePulse"}, {30'd0, rotBus.done, rotBus.busy}, 32'd0);
        end
    endtask

    initial begin
        bit           sawActivity;
        logic [N-1:0] firstResult;

        rotBus.start = 1'b0;
        rotBus.In    = '0;
        rotBus.Cnt   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", 32'(rotBus.busy), 32'd0);
        check("reset done", 32'(rotBus.done), 32'd0);
        check("reset Out", 32'(rotBus.Out), 32'd0);
        rst = 1'b0;

        // Basic rotations, zero count, full-minus-one count, wrap of the MSB
        startOp(16'h1234, 4'd4, 1'b1);
        finishOp("rot4", 0, 1'b1);
        startOp(16'h1234, 4'd0, 1'b1);
        finishOp("rot0", 0, 1'b1);
        startOp(16'h1234, 4'd15, 1'b1);
        finishOp("rot15", 0, 1'b1);
        startOp(16'h8001, 4'd1, 1'b1);
        finishOp("rot1wrap", 0, 1'b1);

        // start during the 2nd busy cycle is ignored
        startOp(16'h00FF, 4'd8, 1'b1);
        @(negedge clk);
        rotBus.start = 1'b1;
        rotBus.In    = 16'hAAAA;
        rotBus.Cnt   = 4'd3;
        @(negedge clk);
        rotBus.start = 1'b0;
        finishOp("ignoreStart", 2, 1'b1);
        sawActivity = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rotBus.busy || rotBus.done) sawActivity = 1'b1;
        end
        check("ignoreStart noReextend", 32'(sawActivity), 32'd0);

        // Back-to-back start accepted in the DONE cycle
        startOp(16'h1234, 4'd4, 1'b1);
        finishOp("b2bFirst", 0, 1'b0);
        firstResult  = rotBus.Out;
        prevOut      = firstResult;
        rotBus.start = 1'b1;
        rotBus.In    = 16'h0001;
        rotBus.Cnt   = 4'd3;
        expQ.push_back(rotModel(16'h0001, 3));
        @(negedge clk);
        rotBus.start = 1'b0;
        check("b2b busyRestart", {30'd0, rotBus.busy, rotBus.done}, 32'd2);
        finishOp("b2bSecond", 0, 1'b1);

        // Reset during the 3rd busy cycle aborts
        startOp(16'hBEEF, 4'd5, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort state", {30'd0, rotBus.busy, rotBus.done}, 32'd0);
        check("abort Out", 32'(rotBus.Out), 32'd0);
        sawActivity = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rotBus.busy || rotBus.done) sawActivity = 1'b1;
        end
        check("abort noDone", 32'(sawActivity), 32'd0);
        startOp(16'hC3A5, 4'd6, 1'b1);
        finishOp("afterAbort", 0, 1'b1);

        // Sweep every count with random operands
        for (int c = 0; c < N; c++) begin
            startOp(N'($urandom), C'(c), 1'b1);
            finishOp($sformatf("sweep%0d", c), 0, 1'b1);
        end

        check("queue drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
